clk_div_n: RTL and testbench

Programmable integer clock divider, divide-by-N for any N from 2 to 2^WIDTH-1, 50% duty for both even and odd N. Divisor changes are loaded at runtime and applied only at a period boundary, and an enable stops the output cleanly. Each output edge comes from a flop, so the block produces no glitches or runt pulses. Sits in clock-generation logic, feeding derived clocks and a period-start strobe to slower peripherals.

---
 rtl/clk_div_n_if.sv | 24 ++
 rtl/clk_div_n.sv | 114 +++++++++++
 tb/tb_clk_div_n.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_n_if.sv
// Control and status bundle for the programmable clock divider.
// Valid/ready is not used: div_load is a one-cycle strobe qualifying div_in; en is a level.
interface clk_div_n_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [WIDTH-1:0] div_in;
  logic             div_load;
  logic             clk_out;
  logic             tick;
  logic [WIDTH-1:0] div_active;
  logic             running;
  logic             state_dbg;

  modport master (
    output en, div_in, div_load,
    input  clk_out, tick, div_active, running, state_dbg
  );

  modport slave (
    input  en, div_in, div_load,
    output clk_out, tick, div_active, running, state_dbg
  );
endinterface

// File: rtl/clk_div_n.sv
// Divide-by-N clock generator with 50% duty for even and odd N, boundary-aligned
// divisor reload and clean stop; every output edge is launched from a flop.
module clk_div_n #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic       clk,
  input  logic       reset,
  clk_div_n_if.slave bus
);
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  state_e           state, state_n;
  logic [WIDTH-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] div_act, div_act_n;
  logic [WIDTH-1:0] pend, pend_n;
  logic             pend_flag, pend_flag_n;
  logic             pos_q, pos_n;
  logic             neg_q;
  logic             tick_q, tick_n;
  logic             at_start;
  logic [WIDTH-1:0] div_use;
  logic [WIDTH-1:0] half;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pend_n      = pend;
    pend_flag_n = pend_flag;
    pos_n       = 1'b0;
    tick_n      = 1'b0;
    at_start    = 1'b0;
    div_use     = div_act;
    half        = '0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (bus.en) begin
          state_n  = RUN;
          at_start = 1'b1;
        end
      end
      RUN: begin
        if (cnt == div_act - ONE) begin
          at_start = 1'b1;
          cnt_n    = '0;
          if (!bus.en) state_n = IDLE;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
    endcase

    // A pending divisor takes over at the edge that begins a period, so the
    // high-phase length of that very period already uses the new value.
    if (at_start && pend_flag) begin
      div_use     = pend;
      pend_flag_n = 1'b0;
    end
    div_act_n = div_use;
    half      = div_use >> 1;

    if (state_n == RUN) begin
      pos_n  = (cnt_n < half);
      tick_n = (cnt_n == '0);
    end

    // A load coinciding with a boundary is kept for the following boundary.
    if (bus.div_load) begin
      pend_n      = (bus.div_in < TWO) ? TWO : bus.div_in;
      pend_flag_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      div_act   <= DEF;
      pend      <= DEF;
      pend_flag <= 1'b0;
      pos_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      div_act   <= div_act_n;
      pend      <= pend_n;
      pend_flag <= pend_flag_n;
      pos_q     <= pos_n;
      tick_q    <= tick_n;
    end
  end

  // Half-cycle extension of the high phase for odd divisors.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) neg_q <= 1'b0;
    else        neg_q <= pos_q;
  end

  assign bus.clk_out    = div_act[0] ? (pos_q | neg_q) : pos_q;
  assign bus.tick       = tick_q;
  assign bus.div_active = div_act;
  assign bus.running    = (state == RUN);
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_clk_div_n.sv
// Bench for clk_div_n: clk_out is sampled every half clk period and each period
// must be high for exactly N half-cycles and low for N, starting on a posedge.
module tb_clk_div_n;
  localparam int W = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   model_n  = 3;

  clk_div_n_if #(.WIDTH(W)) bus();

  clk_div_n #(.WIDTH(W), .DEFAULT_DIV(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time exceeded, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  function automatic int exp_div(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk or negedge clk);
    #1;
  endtask

  task automatic load_div(input int v);
    bus.div_in   = W'(v);
    bus.div_load = 1'b1;
    @(posedge clk);
    #1;
    bus.div_load = 1'b0;
  endtask

  task automatic wait_rise(input int budget, input string name);
    bit prev;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      prev = bus.clk_out;
      step();
      if (!prev && bus.clk_out) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_rise: got no rising edge, expected one within %0d half-cycles", name, budget);
    end else begin
      checks++;
      if (clk !== 1'b1) begin
        failures++;
        $display("FAIL %s_rise_edge: rise on clk=%0b, expected posedge (1)", name, clk);
      end
    end
  endtask

  // Called on the sample just after a rising edge of clk_out; returns on the next one.
  task automatic measure(input int n, input string name);
    int  hi;
    int  total;
    int  extra;
    bit  prev;
    bit  done;
    hi = 0; total = 0; extra = 0; done = 1'b0;
    checks++;
    if (bus.tick !== 1'b1) begin
      failures++;
      $display("FAIL %s_tick_start: got %0b expected 1", name, bus.tick);
    end
    checks++;
    if (bus.div_active !== W'(n)) begin
      failures++;
      $display("FAIL %s_div_active: got %0d expected %0d", name, bus.div_active, n);
    end
    while (!done && total < 2 * n + 8) begin
      if (bus.clk_out) hi++;
      if (total > 0 && clk && bus.tick) extra++;
      total++;
      prev = bus.clk_out;
      step();
      if (!prev && bus.clk_out) done = 1'b1;
    end
    checks++;
    if (total != 2 * n) begin
      failures++;
      $display("FAIL %s_period: got %0d half-cycles expected %0d", name, total, 2 * n);
    end
    checks++;
    if (hi != n) begin
      failures++;
      $display("FAIL %s_high: got %0d half-cycles expected %0d", name, hi, n);
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL %s_tick_extra: got %0d extra ticks expected 0", name, extra);
    end
    checks++;
    if (clk !== 1'b1) begin
      failures++;
      $display("FAIL %s_next_rise_edge: clk=%0b expected 1", name, clk);
    end
  endtask

  // scenarios
  task automatic test_reset();
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.clk_out !== 1'b0) begin failures++; $display("FAIL reset_clk_out: got %0b expected 0", bus.clk_out); end
    checks++;
    if (bus.tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %0b expected 0", bus.tick); end
    checks++;
    if (bus.running !== 1'b0) begin failures++; $display("FAIL reset_running: got %0b expected 0", bus.running); end
    checks++;
    if (bus.div_active !== W'(3)) begin failures++; $display("FAIL reset_div_active: got %0d expected 3", bus.div_active); end
    bus.en = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.clk_out !== 1'b1) begin failures++; $display("FAIL reset_first_rise: got %0b expected 1", bus.clk_out); end
    checks++;
    if (bus.running !== 1'b1) begin failures++; $display("FAIL reset_running_start: got %0b expected 1", bus.running); end
    measure(3, "reset_p1");
    measure(3, "reset_p2");
    model_n = 3;
  endtask

  task automatic test_sweep(input int a, input int b, input int c, input string name);
    int vals[3];
    vals[0] = a; vals[1] = b; vals[2] = c;
    foreach (vals[i]) begin
      load_div(vals[i]);
      wait_rise(600, name);
      measure(vals[i], name);
      measure(vals[i], name);
      model_n = vals[i];
    end
  endtask

  task automatic test_reload();
    int h;
    int hi;
    bit prev;
    bit done;
    load_div(6);
    wait_rise(600, "reload_setup");
    measure(6, "reload_n6");
    h = 0; hi = 0; done = 1'b0;
    while (!done && h < 40) begin
      if (bus.clk_out) hi++;
      if (h == 4)  begin bus.div_in = W'(3); bus.div_load = 1'b1; end
      if (h == 6)  bus.div_load = 1'b0;
      if (h == 8)  begin bus.div_in = W'(9); bus.div_load = 1'b1; end
      if (h == 10) bus.div_load = 1'b0;
      prev = bus.clk_out;
      step();
      h++;
      if (!prev && bus.clk_out) done = 1'b1;
    end
    checks++;
    if (h != 12) begin failures++; $display("FAIL reload_cur_period: got %0d half-cycles expected 12", h); end
    checks++;
    if (hi != 6) begin failures++; $display("FAIL reload_cur_high: got %0d half-cycles expected 6", hi); end
    measure(9, "reload_n9");
    load_div(0);
    wait_rise(600, "reload_clamp");
    measure(2, "reload_clamp");
    model_n = 2;
  endtask

  task automatic test_enable();
    int hi;
    int late_hi;
    int late_run;
    load_div(5);
    wait_rise(600, "enable_setup");
    hi = 0;
    for (int h = 0; h < 10; h++) begin
      if (bus.clk_out) hi++;
      if (h == 2) bus.en = 1'b0;
      if (h == 4) bus.en = 1'b1;
      if (h == 6) bus.en = 1'b0;
      step();
    end
    checks++;
    if (hi != 5) begin failures++; $display("FAIL enable_last_high: got %0d half-cycles expected 5", hi); end
    checks++;
    if (bus.clk_out !== 1'b0) begin failures++; $display("FAIL enable_stop_out: got %0b expected 0", bus.clk_out); end
    checks++;
    if (bus.running !== 1'b0) begin failures++; $display("FAIL enable_stop_running: got %0b expected 0", bus.running); end
    checks++;
    if (bus.tick !== 1'b0) begin failures++; $display("FAIL enable_stop_tick: got %0b expected 0", bus.tick); end
    late_hi = 0; late_run = 0;
    for (int h = 0; h < 40; h++) begin
      step();
      if (bus.clk_out) late_hi++;
      if (bus.running) late_run++;
    end
    checks++;
    if (late_hi != 0) begin failures++; $display("FAIL enable_idle_out: got %0d high samples expected 0", late_hi); end
    checks++;
    if (late_run != 0) begin failures++; $display("FAIL enable_idle_running: got %0d running samples expected 0", late_run); end
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.clk_out !== 1'b1) begin failures++; $display("FAIL enable_restart: got %0b expected 1", bus.clk_out); end
    measure(5, "enable_restart");
    model_n = 5;
  endtask

  task automatic test_async_reset();
    load_div(7);
    wait_rise(600, "areset_setup");
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (bus.clk_out !== 1'b1) begin failures++; $display("FAIL areset_pre_high: got %0b expected 1", bus.clk_out); end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.clk_out !== 1'b0) begin failures++; $display("FAIL areset_clk_out: got %0b expected 0", bus.clk_out); end
    checks++;
    if (bus.tick !== 1'b0) begin failures++; $display("FAIL areset_tick: got %0b expected 0", bus.tick); end
    checks++;
    if (bus.div_active !== W'(3)) begin failures++; $display("FAIL areset_div_active: got %0d expected 3", bus.div_active); end
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.clk_out !== 1'b1) begin failures++; $display("FAIL areset_restart: got %0b expected 1", bus.clk_out); end
    measure(3, "areset_p1");
    measure(3, "areset_p2");
    model_n = 3;
  endtask

  // Random bursts of loads inside one period; the last load wins at the next boundary.
  task automatic test_random();
    int k;
    int d;
    int v;
    int last;
    int kmax;
    for (int it = 0; it < 8; it++) begin
      kmax = (model_n - 1 < 3) ? model_n - 1 : 3;
      k = int'($urandom_range(kmax, 1));
      d = int'($urandom_range(model_n - 1 - k, 0));
      repeat (d) begin
        @(posedge clk);
        #1;
      end
      last = 2;
      for (int j = 0; j < k; j++) begin
        if ($urandom_range(3, 0) == 0) v = int'($urandom_range(1, 0));
        else                           v = int'($urandom_range(40, 2));
        last = v;
        load_div(v);
      end
      wait_rise(600, "random");
      measure(exp_div(last), "random");
      model_n = exp_div(last);
    end
  endtask

  // sequence and final report
  initial begin
    bus.en = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;
    test_reset();
    test_sweep(2, 4, 10, "even");
    test_sweep(5, 7, 255, "odd");
    test_reload();
    test_enable();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
